// File: rtl/aes_types.sv
// Shared tower-field types and helpers for the composite-field AES S-box.
// GF(2^4) is built as GF((2^2)^2); the helpers here are reused by the other
// tower-field blocks (multipliers, inverters, scalers).
package aes_types;

  localparam int GF2_W = 2;
  localparam int GF4_W = 4;

  // Squaring in GF(2^2) with a normal basis is a plain swap of the two bits.
  function automatic logic [GF2_W-1:0] gf_sq_2(input logic [GF2_W-1:0] p);
    return {p[0], p[1]};
  endfunction

  // Scaling by w in GF(2^2), normal basis.
  function automatic logic [GF2_W-1:0] gf_sclw2_2(input logic [GF2_W-1:0] p);
    return {p[0], p[1] ^ p[0]};
  endfunction

endpackage

// File: rtl/gf_sq_scl_4_core.sv
// Combinational Q = nu * x^2 over GF(2^4). XOR-only linear map.
module gf_sq_scl_4_core
  import aes_types::*;
(
  input  logic [GF4_W-1:0] data_in,
  output logic [GF4_W-1:0] data_out
);

  logic [GF2_W-1:0] a;
  logic [GF2_W-1:0] b;

  assign a = data_in[GF4_W-1:GF2_W];
  assign b = data_in[GF2_W-1:0];

  // High half: (a+b)^2; low half: w * b^2.
  assign data_out = {gf_sq_2(a ^ b), gf_sclw2_2(gf_sq_2(b))};

endmodule

// File: rtl/gf_sq_scl_4.sv
// Square-and-scale block for the GF(2^4) inverter, with an optional output
// register stage and valid tracking for use in a pipelined S-box.
module gf_sq_scl_4
  import aes_types::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [GF4_W-1:0] data_in,
  output logic             out_valid,
  output logic [GF4_W-1:0] data_out
);

  logic [GF4_W-1:0] f_x;

  gf_sq_scl_4_core u_core (
    .data_in  (data_in),
    .data_out (f_x)
  );

  if (OUT_REG) begin : g_reg
    logic             valid_q;
    logic [GF4_W-1:0] data_q;

    // One-cycle register stage; data holds when no new sample arrives.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) data_q <= f_x;
      end
    end

    assign out_valid = valid_q;
    assign data_out  = data_q;
  end else begin : g_comb
    // Pass-through: clk and rst are intentionally unused in this variant.
    assign out_valid = in_valid;
    assign data_out  = f_x;
  end

endmodule

// File: tb/tb_gf_sq_scl_4.sv
module tb_gf_sq_scl_4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] data_in;
  logic       out_valid;
  logic [3:0] data_out;

  logic       c_rst;
  logic       c_valid;
  logic [3:0] c_data;
  logic       c_out_valid;
  logic [3:0] c_out;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q[$];
  logic [3:0] ftab[16];
  logic [15:0] seen;
  logic        sweep_on;

  always #5 clk = ~clk;

  gf_sq_scl_4 #(.OUT_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out)
  );

  gf_sq_scl_4 #(.OUT_REG(1'b0)) dut_c (
    .clk(clk), .rst(c_rst), .in_valid(c_valid), .data_in(c_data),
    .out_valid(c_out_valid), .data_out(c_out)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus; push expectation if a sample is accepted.
  task automatic drive(input logic r, input logic v, input logic [3:0] d);
    rst = r; in_valid = v; data_in = d;
    if (v && !r) exp_q.push_back(ftab[d]);
    @(posedge clk); #1;
  endtask

  // Monitor: pop and compare whenever the DUT presents a valid output.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 4'h1, 4'h0);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("scoreboard_data", data_out, e);
        if (sweep_on) seen[data_out] = 1'b1;
      end
    end
  end

  initial begin
    ftab = '{4'h0, 4'h9, 4'h7, 4'hE, 4'h8, 4'h1, 4'hF, 4'h6,
             4'h4, 4'hD, 4'h3, 4'hA, 4'hC, 4'h5, 4'hB, 4'h2};
    seen = '0; sweep_on = 1'b0;
    rst = 1'b1; in_valid = 1'b0; data_in = 4'h0;
    c_rst = 1'b0; c_valid = 1'b0; c_data = 4'h0;

    // Reset state
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h0);
    check("reset_data", data_out, 4'h0);
    check("reset_valid", {3'b0, out_valid}, 4'h0);

    // Exhaustive back-to-back sweep
    sweep_on = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i));
    drive(1'b0, 1'b0, 4'h0);
    @(negedge clk);
    sweep_on = 1'b0;
    check("sweep_all_distinct", {3'b0, (seen == 16'hFFFF)}, 4'h1);

    // Reset mid-stream with valid input present
    drive(1'b1, 1'b1, 4'h3);
    check("rst1_data", data_out, 4'h0);
    check("rst1_valid", {3'b0, out_valid}, 4'h0);
    drive(1'b1, 1'b1, 4'h3);
    check("rst2_data", data_out, 4'h0);
    check("rst2_valid", {3'b0, out_valid}, 4'h0);
    drive(1'b0, 1'b1, 4'h3);
    check("post_rst_data", data_out, 4'hE);
    check("post_rst_valid", {3'b0, out_valid}, 4'h1);

    // Hold behaviour
    drive(1'b0, 1'b1, 4'h1);
    check("hold_load", data_out, 4'h9);
    drive(1'b0, 1'b0, 4'hF);
    check("hold_data", data_out, 4'h9);
    check("hold_valid", {3'b0, out_valid}, 4'h0);
    drive(1'b0, 1'b0, 4'hF);
    check("hold_data2", data_out, 4'h9);

    // Linearity spot checks
    drive(1'b0, 1'b1, 4'hC);
    check("lin_C", data_out, 4'hC);
    drive(1'b0, 1'b1, 4'hF);
    check("lin_F", data_out, 4'h2);
    drive(1'b0, 1'b0, 4'h0);

    // Combinational variant: same-cycle response, reset has no effect
    @(posedge clk); #2;
    c_valid = 1'b1; c_data = 4'h2; #1;
    check("comb_2", c_out, 4'h7);
    check("comb_valid", {3'b0, c_out_valid}, 4'h1);
    c_rst = 1'b1; #1;
    check("comb_rst_data", c_out, 4'h7);
    check("comb_rst_valid", {3'b0, c_out_valid}, 4'h1);
    c_data = 4'h1; #1;
    begin
      logic [3:0] f1, f2, f3;
      f1 = c_out;
      c_data = 4'h2; #1; f2 = c_out;
      c_data = 4'h3; #1; f3 = c_out;
      check("comb_linear_1_2", f1 ^ f2, 4'hE);
      check("comb_f3", f3, 4'hE);
    end
    c_rst = 1'b0; c_valid = 1'b0; #1;
    check("comb_valid_low", {3'b0, c_out_valid}, 4'h0);

    // Drain scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_empty", 4'(exp_q.size()), 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
